// File: rtl/handshake_pipe.sv
// handshake_pipe: valid/ready FIFO buffer whose upstream ready depends only on registered state.
// Defining HANDSHAKE_PIPE_BYPASS_EN lets a word pass straight through when the buffer is empty.
module handshake_pipe #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       valid_pre_i,
  input  logic [DATA_W-1:0]          data_i,
  output logic                       ready_pre_o,
  output logic                       valid_post_o,
  output logic [DATA_W-1:0]          data_o,
  input  logic                       ready_post_i,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_FULL
  } occ_e;

  occ_e              state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic push;
  logic pop;
  logic bypass;
  logic store;
  logic drain;

  assign ready_pre_o = (state_q != ST_FULL);
  assign level_o     = level_q;

`ifdef HANDSHAKE_PIPE_BYPASS_EN
  // An empty buffer exposes the upstream word directly; it is only stored if nobody takes it.
  assign bypass = (state_q == ST_EMPTY) && valid_pre_i && ready_post_i;

  always_comb begin
    valid_post_o = 1'b1;
    data_o       = mem_q[rd_ptr_q];
    if (state_q == ST_EMPTY) begin
      valid_post_o = valid_pre_i;
      data_o       = data_i;
    end
  end
`else
  assign bypass       = 1'b0;
  assign valid_post_o = (state_q != ST_EMPTY);
  assign data_o       = valid_post_o ? mem_q[rd_ptr_q] : '0;
`endif

  assign push  = valid_pre_i && ready_pre_o;
  assign pop   = valid_post_o && ready_post_i;
  assign store = push && !bypass;
  assign drain = pop && !bypass;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    mem_d    = mem_q;

    if (store) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (drain) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    if (store && !drain) begin
      level_d = level_q + LW'(1);
    end else if (drain && !store) begin
      level_d = level_q - LW'(1);
    end
  end

  // Occupancy class tracks the next level so ready/valid come straight from flops.
  always_comb begin
    state_d = ST_PARTIAL;
    if (level_d == '0) begin
      state_d = ST_EMPTY;
    end else if (level_d == FULL_LVL) begin
      state_d = ST_FULL;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_handshake_pipe.sv
// tb_handshake_pipe: directed and randomized-handshake checks of handshake_pipe (DEPTH=4, DATA_W=8).
// Bypass-specific expectations follow HANDSHAKE_PIPE_BYPASS_EN when it is defined.
module tb_handshake_pipe;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int LW     = $clog2(DEPTH + 1);
`ifdef HANDSHAKE_PIPE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              valid_pre_i;
  logic [DATA_W-1:0] data_i;
  logic              ready_pre_o;
  logic              valid_post_o;
  logic [DATA_W-1:0] data_o;
  logic              ready_post_i;
  logic [LW-1:0]     level_o;

  int tests_run    = 0;
  int tests_failed = 0;

  handshake_pipe #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .valid_pre_i  (valid_pre_i),
    .data_i       (data_i),
    .ready_pre_o  (ready_pre_o),
    .valid_post_o (valid_post_o),
    .data_o       (data_o),
    .ready_post_i (ready_post_i),
    .level_o      (level_o)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    reset_n      = 1'b0;
    valid_pre_i  = 1'b1;
    data_i       = 8'hFF;
    ready_post_i = 1'b1;
    repeat (5) @(negedge clk);
    valid_pre_i  = 1'b0;
    data_i       = 8'h00;
    ready_post_i = 1'b0;
    #1;
    tests_run++;
    if (level_o !== LW'(0)) begin
      tests_failed++;
      $display("[TB] FAIL reset_level got %0d want 0", level_o);
    end
    tests_run++;
    if (valid_post_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_valid got %b want 0", valid_post_o);
    end
    tests_run++;
    if (ready_pre_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_ready got %b want 1", ready_pre_o);
    end
    tests_run++;
    if (data_o !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_data got %h want 00", data_o);
    end
  endtask

  // Reset releases together with the first push; words 1,2,3 stream through.
  task automatic test_stream;
    reset_n      = 1'b1;
    valid_pre_i  = 1'b1;
    ready_post_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      data_i = 8'(i);
`ifdef HANDSHAKE_PIPE_BYPASS_EN
      #1;
      tests_run++;
      if (data_o !== 8'(i) || level_o !== LW'(0)) begin
        tests_failed++;
        $display("[TB] FAIL stream_word%0d got data %0d level %0d want data %0d level 0", i, data_o, level_o, i);
      end
      @(negedge clk);
`else
      @(negedge clk);
      tests_run++;
      if (data_o !== 8'(i) || level_o !== LW'(1) || valid_post_o !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL stream_word%0d got data %0d level %0d valid %b want data %0d level 1 valid 1",
                 i, data_o, level_o, valid_post_o, i);
      end
`endif
    end
    valid_pre_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (level_o !== LW'(0) || valid_post_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL stream_drained got level %0d valid %b want level 0 valid 0", level_o, valid_post_o);
    end
  endtask

  task automatic test_empty_path;
    valid_pre_i  = 1'b1;
    ready_post_i = 1'b1;
`ifdef HANDSHAKE_PIPE_BYPASS_EN
    data_i = 8'hA5;
    #1;
    tests_run++;
    if (data_o !== 8'hA5 || valid_post_o !== 1'b1 || level_o !== LW'(0)) begin
      tests_failed++;
      $display("[TB] FAIL bypass_pass got data %h valid %b level %0d want a5 1 0", data_o, valid_post_o, level_o);
    end
    @(negedge clk);
    tests_run++;
    if (level_o !== LW'(0)) begin
      tests_failed++;
      $display("[TB] FAIL bypass_nostore got level %0d want 0", level_o);
    end
    ready_post_i = 1'b0;
    data_i       = 8'h5A;
    #1;
    tests_run++;
    if (data_o !== 8'h5A || valid_post_o !== 1'b1 || ready_pre_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bypass_stall got data %h valid %b ready %b want 5a 1 1", data_o, valid_post_o, ready_pre_o);
    end
    @(negedge clk);
    valid_pre_i = 1'b0;
    data_i      = 8'h00;
    #1;
    tests_run++;
    if (data_o !== 8'h5A || level_o !== LW'(1)) begin
      tests_failed++;
      $display("[TB] FAIL bypass_stored got data %h level %0d want 5a 1", data_o, level_o);
    end
    ready_post_i = 1'b1;
`else
    data_i = 8'h5A;
    #1;
    tests_run++;
    if (valid_post_o !== 1'b0 || data_o !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL empty_nocomb got valid %b data %h want 0 00", valid_post_o, data_o);
    end
    @(negedge clk);
    valid_pre_i = 1'b0;
    tests_run++;
    if (data_o !== 8'h5A || level_o !== LW'(1)) begin
      tests_failed++;
      $display("[TB] FAIL empty_push got data %h level %0d want 5a 1", data_o, level_o);
    end
`endif
    @(negedge clk);
    tests_run++;
    if (level_o !== LW'(0) || valid_post_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL empty_pop got level %0d valid %b want 0 0", level_o, valid_post_o);
    end
    ready_post_i = 1'b0;
  endtask

  task automatic test_full;
    int exp_lvl;
    valid_pre_i  = 1'b1;
    ready_post_i = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      data_i = 8'(10 + k);
      @(negedge clk);
      exp_lvl = (k < DEPTH) ? k : DEPTH;
      tests_run++;
      if (level_o !== LW'(exp_lvl) || ready_pre_o !== (exp_lvl != DEPTH) || data_o !== 8'd11) begin
        tests_failed++;
        $display("[TB] FAIL full_attempt%0d got level %0d ready %b data %0d want level %0d ready %b data 11",
                 k, level_o, ready_pre_o, data_o, exp_lvl, exp_lvl != DEPTH);
      end
    end
  endtask

  // One pop from FULL with upstream still valid: the upstream word must not sneak in.
  task automatic test_full_pop;
    data_i       = 8'd99;
    valid_pre_i  = 1'b1;
    ready_post_i = 1'b1;
    @(negedge clk);
    valid_pre_i  = 1'b0;
    ready_post_i = 1'b0;
    data_i       = 8'd0;
    #1;
    tests_run++;
    if (level_o !== LW'(3) || ready_pre_o !== 1'b1 || data_o !== 8'd12) begin
      tests_failed++;
      $display("[TB] FAIL fullpop_state got level %0d ready %b data %0d want 3 1 12", level_o, ready_pre_o, data_o);
    end
    ready_post_i = 1'b1;
    for (int w = 13; w <= 14; w++) begin
      @(negedge clk);
      tests_run++;
      if (data_o !== 8'(w)) begin
        tests_failed++;
        $display("[TB] FAIL fullpop_drain got data %0d want %0d", data_o, w);
      end
    end
    @(negedge clk);
    tests_run++;
    if (level_o !== LW'(0) || valid_post_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL fullpop_empty got level %0d valid %b want 0 0", level_o, valid_post_o);
    end
    ready_post_i = 1'b0;
  endtask

  task automatic test_reset_mid;
    valid_pre_i  = 1'b1;
    ready_post_i = 1'b0;
    for (int w = 21; w <= 23; w++) begin
      data_i = 8'(w);
      @(negedge clk);
    end
    tests_run++;
    if (level_o !== LW'(3)) begin
      tests_failed++;
      $display("[TB] FAIL midreset_fill got level %0d want 3", level_o);
    end
    reset_n      = 1'b0;
    data_i       = 8'd77;
    ready_post_i = 1'b1;
    @(negedge clk);
    reset_n      = 1'b1;
    valid_pre_i  = 1'b0;
    ready_post_i = 1'b0;
    data_i       = 8'd0;
    #1;
    tests_run++;
    if (level_o !== LW'(0) || valid_post_o !== 1'b0 || data_o !== 8'd0 || ready_pre_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midreset_clear got level %0d valid %b data %0d ready %b want 0 0 0 1",
               level_o, valid_post_o, data_o, ready_pre_o);
    end
    valid_pre_i = 1'b1;
    data_i      = 8'd31;
    @(negedge clk);
    valid_pre_i = 1'b0;
    data_i      = 8'd0;
    #1;
    tests_run++;
    if (data_o !== 8'd31 || level_o !== LW'(1)) begin
      tests_failed++;
      $display("[TB] FAIL midreset_first got data %0d level %0d want 31 1", data_o, level_o);
    end
    ready_post_i = 1'b1;
    @(negedge clk);
    tests_run++;
    if (level_o !== LW'(0)) begin
      tests_failed++;
      $display("[TB] FAIL midreset_drain got level %0d want 0", level_o);
    end
    ready_post_i = 1'b0;
  endtask

  // Incrementing words 1..200 under random handshakes; the reference is a counter plus a level model.
  task automatic test_random;
    int  next_push = 1;
    int  exp_pop   = 1;
    int  mlevel    = 0;
    int  cycles    = 0;
    bit  exp_rdy;
    bit  exp_vld;
    bit  push;
    bit  pop;
    while (exp_pop <= 200 && cycles < 5000) begin
      @(negedge clk);
      valid_pre_i  = (next_push <= 200) && ($urandom_range(0, 9) < 7);
      data_i       = 8'(next_push);
      ready_post_i = ($urandom_range(0, 9) < 5);
      #1;
      exp_rdy = (mlevel != DEPTH);
      exp_vld = (mlevel != 0) || (BYP && valid_pre_i);
      push    = valid_pre_i && exp_rdy;
      pop     = exp_vld && ready_post_i;
      tests_run++;
      if (ready_pre_o !== exp_rdy || valid_post_o !== exp_vld || level_o !== LW'(mlevel)) begin
        tests_failed++;
        $display("[TB] FAIL random_flags cycle %0d got ready %b valid %b level %0d want %b %b %0d",
                 cycles, ready_pre_o, valid_post_o, level_o, exp_rdy, exp_vld, mlevel);
      end
      if (pop) begin
        tests_run++;
        if (data_o !== 8'(exp_pop)) begin
          tests_failed++;
          $display("[TB] FAIL random_data got %0d want %0d", data_o, exp_pop);
        end
        exp_pop++;
      end
      if (push) next_push++;
      mlevel = mlevel + int'(push) - int'(pop);
      cycles++;
    end
    tests_run++;
    if (exp_pop != 201) begin
      tests_failed++;
      $display("[TB] FAIL random_timeout got %0d words want 200", exp_pop - 1);
    end
    @(negedge clk);
    valid_pre_i  = 1'b0;
    ready_post_i = 1'b0;
  endtask

  initial begin
    reset_n      = 1'b0;
    valid_pre_i  = 1'b0;
    data_i       = '0;
    ready_post_i = 1'b0;
    test_reset();
    test_stream();
    test_empty_path();
    test_full();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/handshake_pipe.md
HANDSHAKE_PIPE -- requirements
Module: handshake_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning payload width in bits (legal range 1..64).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning buffer entries (power of two, 2..64).
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port valid_pre_i  input  1  upstream valid.
REQ-006 The block SHALL have port data_i  input  DATA_W  upstream payload.
REQ-007 The block SHALL have port ready_pre_o  output  1  upstream ready.
REQ-008 The block SHALL have port valid_post_o  output  1  downstream valid.
REQ-009 The block SHALL have port data_o  output  DATA_W  downstream payload.
REQ-010 The block SHALL have port ready_post_i  input  1  downstream ready.
REQ-011 The block SHALL have port level_o  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.

Function
REQ-012 A push SHALL occur on a rising edge where valid_pre_i and ready_pre_o are both 1, and a pop SHALL occur on a rising edge where valid_post_o and ready_post_i are both 1.
REQ-013 ready_pre_o SHALL equal (level_o != DEPTH), derived only from registered state, with no combinational path from ready_post_i.
REQ-014 valid_post_o SHALL equal (level_o != 0), and data_o SHALL present the oldest stored entry.
REQ-015 Order SHALL be strict FIFO: no loss, duplication or reordering of pushed words.
REQ-016 Latency SHALL be 1 cycle: a word pushed at edge N is visible on data_o/valid_post_o after edge N, if all older words have drained.
REQ-017 Throughput SHALL be one word per cycle sustained when valid_pre_i=1 and ready_post_i=1 continuously, with level_o constant.
REQ-018 Occupancy state SHALL be EMPTY (level 0), PARTIAL (1..DEPTH-1) or FULL (DEPTH): push only increments, pop only decrements, push+pop holds level.
REQ-019 When FULL with ready_post_i=1, only the pop SHALL occur that edge and ready_pre_o SHALL rise the following cycle, with no same-cycle pass-through.
REQ-020 When EMPTY, no pop SHALL occur, and a push SHALL make valid_post_o=1 next cycle.
REQ-021 Read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0 without a gap.
REQ-022 While valid_post_o=1 and ready_post_i=0, data_o and valid_post_o SHALL remain stable.
REQ-023 data_i SHALL be ignored when no push occurs, and storage SHALL never be written when level_o=DEPTH.

Reset
REQ-024 On a rising edge with reset_n=0, pointers and level SHALL clear, giving level_o=0, valid_post_o=0, ready_pre_o=1 and data_o=0 after that edge.
REQ-025 Reset asserted mid-transfer SHALL discard all stored words with priority over a same-edge push or pop, and no word pushed before reset SHALL appear afterwards.
REQ-026 The first push after reset_n rises SHALL be accepted at the first edge with reset_n=1.

Configuration
REQ-027 With macro HANDSHAKE_PIPE_BYPASS_EN defined, when level_o=0, valid_pre_i=1 and ready_post_i=1, the word SHALL pass combinationally (data_o=data_i, valid_post_o=1, zero latency) and SHALL not be stored, level staying 0.
REQ-028 With HANDSHAKE_PIPE_BYPASS_EN defined and level_o=0, valid_post_o SHALL equal valid_pre_i and data_o SHALL equal data_i, and ready_pre_o SHALL remain registered-only.
REQ-029 Without HANDSHAKE_PIPE_BYPASS_EN, behaviour SHALL be exactly REQ-012..REQ-023, with no combinational path from inputs to valid_post_o/data_o.

Verification
REQ-030 Bench SHALL drive a reset of 5 cycles then valid_pre_i=1 with data 1,2,3 and ready_post_i=1 -> data_o reads 1,2,3 on consecutive cycles starting 1 cycle after the first push, with level_o=1 throughout.
REQ-031 Bench SHALL drive DEPTH=4, ready_post_i=0, 6 push attempts -> level_o=4, ready_pre_o=0 after the 4th push, and words 5-6 not accepted until ready_post_i rises.
REQ-032 Bench SHALL hold FULL then assert ready_post_i=1 for 1 cycle with valid_pre_i=1 -> one pop, no push that edge, level_o=3, ready_pre_o=1 next cycle.
REQ-033 Bench SHALL drive random valid_pre_i/ready_post_i with incrementing 8-bit data 1..200 -> receiver check data_o==expected on every pop with 0 errors, including pointer wrap past entry 3.
REQ-034 Bench SHALL assert reset_n=0 for 1 edge with level_o=3 and ready_post_i=0 -> level_o=0, valid_post_o=0, data_o=0, and the next output word is the first one pushed after reset.
REQ-035 Bench SHALL, with HANDSHAKE_PIPE_BYPASS_EN and the block empty, drive valid_pre_i=1, data_i=8'hA5, ready_post_i=1 -> data_o=8'hA5 same cycle, level_o stays 0.
